multicycle_control: RTL and testbench

Multicycle control unit for the 16-bit RISC core. A Moore/Mealy FSM sequences each instruction through fetch, decode, execute, memory and write-back, and drives every datapath enable: PC, instruction register, register file, ALU and memory. Inputs are the instruction-register fields (opcode, m), the ALU zero flag and the memory ready handshake.

---
 rtl/core_defs.sv | 59 +++++
 rtl/ctrl_decode.sv | 118 +++++++++++
 rtl/multicycle_control.sv | 83 ++++++++
 tb/tb_multicycle_control.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/core_defs.sv
// rtl/core_defs.sv - shared encodings for the multicycle control unit
// Purpose: state, opcode, alu_op, pc_src and wb_src encodings plus the
//          bundled control-output struct used between decode and top.
// Ports:   none (package).
package core_defs;

  // FSM state encodings (6 and 7 are unused and recover to FETCH)
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  // Opcodes (9..14 are unimplemented)
  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_SW   = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_BNE  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  // ALU operation codes
  localparam logic [1:0] ALU_AND = 2'd0;
  localparam logic [1:0] ALU_ADD = 2'd1;
  localparam logic [1:0] ALU_SUB = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  // PC source select
  localparam logic [1:0] PC_PLUS1  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // Write-back source select
  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  // All datapath controls in one bundle so the top can gate them as a unit
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       alu_src_b;
    logic       reg_write;
    logic       wb_src;
    logic       instr_done;
    logic       illegal;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational next-state and control-output decode
// Purpose: maps the current state, latched instruction fields, zero flag and
//          memory handshake to the control bundle and the next state.
// Ports:   state      in  3  current FSM state
//          opcode     in  4  live opcode, consulted only in DECODE
//          op_q       in  4  opcode latched at the end of DECODE
//          m_q        in  1  operand-B select latched at the end of DECODE
//          zero       in  1  ALU zero flag
//          mem_ready  in  1  memory completion handshake
//          next_state out 3  state to load on the next clock edge
//          ctrl       out    control bundle (ctrl_t)
import core_defs::*;

module ctrl_decode (
  input  logic [2:0] state,
  input  logic [3:0] opcode,
  input  logic [3:0] op_q,
  input  logic       m_q,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] next_state,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl       = '0;
    next_state = ST_FETCH;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b0;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_PLUS1;
          next_state    = ST_DECODE;
        end else begin
          next_state    = ST_FETCH;
        end
      end

      // op_q is only loaded at the end of this cycle, so decode the live field
      ST_DECODE: begin
        if (opcode <= OP_BNE) begin
          next_state = ST_EXEC;
        end else if (opcode == OP_JMP) begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_src     = PC_JUMP;
          ctrl.instr_done = 1'b1;
          next_state      = ST_FETCH;
        end else if (opcode == OP_HALT) begin
          ctrl.instr_done = 1'b1;
          next_state      = ST_HALT;
        end else begin
          ctrl.illegal    = 1'b1;
          ctrl.instr_done = 1'b1;
          next_state      = ST_FETCH;
        end
      end

      ST_EXEC: begin
        case (op_q)
          OP_AND, OP_ADD, OP_SUB, OP_OR: begin
            ctrl.alu_op    = op_q[1:0];
            ctrl.alu_src_b = m_q;
            next_state     = ST_WB;
          end
          OP_LW, OP_SW: begin
            ctrl.alu_op    = ALU_ADD;
            ctrl.alu_src_b = 1'b1;
            next_state     = ST_MEM;
          end
          OP_BEQ, OP_BNE: begin
            ctrl.alu_op     = ALU_SUB;
            ctrl.alu_src_b  = 1'b0;
            ctrl.pc_write   = (op_q == OP_BEQ) ? zero : !zero;
            ctrl.pc_src     = PC_BRANCH;
            ctrl.instr_done = 1'b1;
            next_state      = ST_FETCH;
          end
          default: next_state = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        ctrl.iord = 1'b1;
        if (op_q == OP_SW) begin
          ctrl.mem_write = 1'b1;
        end else begin
          ctrl.mem_read  = 1'b1;
        end
        if (!mem_ready) begin
          next_state = ST_MEM;
        end else if (op_q == OP_SW) begin
          ctrl.instr_done = 1'b1;
          next_state      = ST_FETCH;
        end else begin
          next_state      = ST_WB;
        end
      end

      ST_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.wb_src     = (op_q == OP_LW) ? WB_MEM : WB_ALU;
        ctrl.instr_done = 1'b1;
        next_state      = ST_FETCH;
      end

      ST_HALT: begin
        ctrl.halted = 1'b1;
        next_state  = ST_HALT;
      end

      default: next_state = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle control FSM for the 16-bit RISC core
// Purpose: holds the state and latched instruction fields, and gates every
//          control output to 0 while reset is asserted.
// Ports:   clk, rst_n (sync active-low), opcode[3:0], m, zero, mem_ready in;
//          state[2:0], pc_write, pc_src[1:0], ir_write, iord, mem_read,
//          mem_write, alu_op[1:0], alu_src_b, reg_write, wb_src, instr_done,
//          illegal, halted out.
import core_defs::*;

module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       m,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] alu_op,
  output logic       alu_src_b,
  output logic       reg_write,
  output logic       wb_src,
  output logic       instr_done,
  output logic       illegal,
  output logic       halted
);

  logic [2:0] state_q;
  logic [2:0] next_state;
  logic [3:0] op_q;
  logic       m_q;
  ctrl_t      dec_ctrl;
  ctrl_t      ctrl;

  ctrl_decode u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .op_q       (op_q),
    .m_q        (m_q),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .next_state (next_state),
    .ctrl       (dec_ctrl)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      op_q    <= 4'd0;
      m_q     <= 1'b0;
    end else begin
      state_q <= next_state;
      if (state_q == ST_DECODE) begin
        op_q <= opcode;
        m_q  <= m;
      end
    end
  end

  // Reset drops any pending memory request immediately, not at the next edge
  assign ctrl  = rst_n ? dec_ctrl : '0;
  assign state = rst_n ? state_q  : ST_FETCH;

  assign pc_write   = ctrl.pc_write;
  assign pc_src     = ctrl.pc_src;
  assign ir_write   = ctrl.ir_write;
  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign alu_op     = ctrl.alu_op;
  assign alu_src_b  = ctrl.alu_src_b;
  assign reg_write  = ctrl.reg_write;
  assign wb_src     = ctrl.wb_src;
  assign instr_done = ctrl.instr_done;
  assign illegal    = ctrl.illegal;
  assign halted     = ctrl.halted;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       m;
  logic       zero;
  logic       mem_ready;
  logic [2:0] state;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] alu_op;
  logic       alu_src_b;
  logic       reg_write;
  logic       wb_src;
  logic       instr_done;
  logic       illegal;
  logic       halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .m          (m),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .state      (state),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_op     (alu_op),
    .alu_src_b  (alu_src_b),
    .reg_write  (reg_write),
    .wb_src     (wb_src),
    .instr_done (instr_done),
    .illegal    (illegal),
    .halted     (halted)
  );

  logic [14:0] outs;
  assign outs = {pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                 alu_op, alu_src_b, reg_write, wb_src, instr_done, illegal, halted};

  // Packs hand-written expected control values in the same order as outs
  function automatic logic [14:0] ov(
    input logic pcw, input logic [1:0] pcs, input logic irw, input logic ird,
    input logic mr, input logic mw, input logic [1:0] aop, input logic asb,
    input logic rw, input logic wbs, input logic dn, input logic ill, input logic hlt);
    return {pcw, pcs, irw, ird, mr, mw, aop, asb, rw, wbs, dn, ill, hlt};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Check state and all outputs mid-cycle, then advance one clock
  task automatic cyc(input string tag, input logic [2:0] st, input logic [14:0] exp);
    #1;
    check({tag, "_state"}, {29'd0, state}, {29'd0, st});
    check({tag, "_outs"}, {17'd0, outs}, {17'd0, exp});
    @(posedge clk);
    #1;
  endtask

  localparam logic [14:0] FETCH_GO   = 15'b1_00_1_0_1_0_00_0_0_0_0_0_0;
  localparam logic [14:0] FETCH_WAIT = 15'b0_00_0_0_1_0_00_0_0_0_0_0_0;

  initial begin
    rst_n = 1'b0; opcode = 4'd0; m = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check("reset_state", {29'd0, state}, 32'd0);
    #1;
    check("reset_outs", {17'd0, outs}, 32'd0);
    rst_n = 1'b1;

    // FETCH stall, then ADD m=1
    cyc("fetch_stall", 3'd0, FETCH_WAIT);
    mem_ready = 1'b1; opcode = 4'd1; m = 1'b1;
    cyc("add_fetch", 3'd0, FETCH_GO);
    cyc("add_dec", 3'd1, 15'd0);
    opcode = 4'd3; m = 1'b0;   // must be ignored outside DECODE
    cyc("add_exec", 3'd2, ov(0,0,0,0,0,0,2'd1,1,0,0,0,0,0));
    cyc("add_wb", 3'd4, ov(0,0,0,0,0,0,2'd0,0,1,0,1,0,0));

    // LW with two MEM wait cycles
    opcode = 4'd4; m = 1'b0;
    cyc("lw_fetch", 3'd0, FETCH_GO);
    cyc("lw_dec", 3'd1, 15'd0);
    cyc("lw_exec", 3'd2, ov(0,0,0,0,0,0,2'd1,1,0,0,0,0,0));
    mem_ready = 1'b0;
    cyc("lw_mem0", 3'd3, ov(0,0,0,1,1,0,2'd0,0,0,0,0,0,0));
    cyc("lw_mem1", 3'd3, ov(0,0,0,1,1,0,2'd0,0,0,0,0,0,0));
    mem_ready = 1'b1;
    cyc("lw_mem2", 3'd3, ov(0,0,0,1,1,0,2'd0,0,0,0,0,0,0));
    cyc("lw_wb", 3'd4, ov(0,0,0,0,0,0,2'd0,0,1,1,1,0,0));

    // BEQ taken, BEQ not taken, BNE taken
    opcode = 4'd6; zero = 1'b1;
    cyc("beq1_fetch", 3'd0, FETCH_GO);
    cyc("beq1_dec", 3'd1, 15'd0);
    cyc("beq1_exec", 3'd2, ov(1,2'd1,0,0,0,0,2'd2,0,0,0,1,0,0));
    zero = 1'b0;
    cyc("beq0_fetch", 3'd0, FETCH_GO);
    cyc("beq0_dec", 3'd1, 15'd0);
    cyc("beq0_exec", 3'd2, ov(0,2'd1,0,0,0,0,2'd2,0,0,0,1,0,0));
    opcode = 4'd7;
    cyc("bne_fetch", 3'd0, FETCH_GO);
    cyc("bne_dec", 3'd1, 15'd0);
    cyc("bne_exec", 3'd2, ov(1,2'd1,0,0,0,0,2'd2,0,0,0,1,0,0));

    // Illegal opcode 10, then JMP
    opcode = 4'd10;
    cyc("ill_fetch", 3'd0, FETCH_GO);
    cyc("ill_dec", 3'd1, ov(0,0,0,0,0,0,2'd0,0,0,0,1,1,0));
    opcode = 4'd8;
    cyc("jmp_fetch", 3'd0, FETCH_GO);
    cyc("jmp_dec", 3'd1, ov(1,2'd2,0,0,0,0,2'd0,0,0,0,1,0,0));

    // HALT is sticky regardless of mem_ready and opcode
    opcode = 4'd15;
    cyc("halt_fetch", 3'd0, FETCH_GO);
    cyc("halt_dec", 3'd1, ov(0,0,0,0,0,0,2'd0,0,0,0,1,0,0));
    for (int i = 0; i < 4; i++) begin
      mem_ready = i[0];
      opcode = 4'd1;
      cyc("halt_hold", 3'd5, ov(0,0,0,0,0,0,2'd0,0,0,0,0,0,1));
    end
    rst_n = 1'b0;
    cyc("halt_rst", 3'd0, 15'd0);
    rst_n = 1'b1; mem_ready = 1'b1;

    // SW interrupted by reset in MEM
    opcode = 4'd5;
    cyc("sw_fetch", 3'd0, FETCH_GO);
    cyc("sw_dec", 3'd1, 15'd0);
    cyc("sw_exec", 3'd2, ov(0,0,0,0,0,0,2'd1,1,0,0,0,0,0));
    mem_ready = 1'b0;
    cyc("sw_mem", 3'd3, ov(0,0,0,1,0,1,2'd0,0,0,0,0,0,0));
    rst_n = 1'b0;
    cyc("sw_rst", 3'd0, 15'd0);
    rst_n = 1'b1; mem_ready = 1'b1; opcode = 4'd0; m = 1'b0;
    cyc("post_fetch", 3'd0, FETCH_GO);
    cyc("post_dec", 3'd1, 15'd0);
    cyc("post_and_exec", 3'd2, 15'd0);
    cyc("post_and_wb", 3'd4, ov(0,0,0,0,0,0,2'd0,0,1,0,1,0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
